// File: rtl/ps2_mouse_packet_rx_if.sv
// ps2_mouse_packet_rx_if
//   Control and result bus of the host-side PS/2 mouse receiver.
//   rx_en      : receive enable (from the host transmitter's tx_idle)
//   byte_valid : 1-cycle pulse, byte_data holds a good frame payload
//   byte_data  : last good received byte
//   frame_err  : 1-cycle pulse on parity/start/stop/timeout error
//   pkt_valid  : 1-cycle pulse, packet fields below were updated
//   buttons    : {middle,right,left}
//   dx, dy     : 9-bit two's complement movement
//   x_ovf/y_ovf: overflow flags from byte 0
//   dz         : wheel movement, present only when PS2_WHEEL_EN is defined
//   master : receiver side, slave : consumer side
interface ps2_mouse_packet_rx_if;
  logic       rx_en;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  logic       pkt_valid;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       x_ovf;
  logic       y_ovf;
`ifdef PS2_WHEEL_EN
  logic [3:0] dz;
`endif

  modport master (
    input  rx_en,
    output byte_valid, byte_data, frame_err, pkt_valid,
           buttons, dx, dy, x_ovf, y_ovf
`ifdef PS2_WHEEL_EN
    , output dz
`endif
  );

  modport slave (
    output rx_en,
    input  byte_valid, byte_data, frame_err, pkt_valid,
           buttons, dx, dy, x_ovf, y_ovf
`ifdef PS2_WHEEL_EN
    , input dz
`endif
  );
endinterface

// File: rtl/ps2_mouse_packet_rx.sv
// ps2_mouse_packet_rx
//   Host-side PS/2 receive stage. Synchronizes and debounces PS2CLK, shifts
//   11-bit device-to-host frames (start, 8 data LSB first, odd parity, stop),
//   and assembles mouse packets into buttons/dx/dy/overflow outputs.
//   Optional build macro PS2_WHEEL_EN: 4-byte IntelliMouse packets, adds dz.
// Ports
//   CLK     : system clock, rising edge
//   RST     : asynchronous active-low reset
//   PS2CLK  : PS/2 clock line (asynchronous input)
//   PS2DATA : PS/2 data line
//   bus     : ps2_mouse_packet_rx_if.master (rx_en in, results out)
// Parameters
//   FILTER_LEN  : consecutive equal samples to accept a PS2CLK change (2..16)
//   TIMEOUT_CYC : idle CLK cycles inside a frame before it is aborted
module ps2_mouse_packet_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   PS2CLK,
  input  logic                   PS2DATA,
  ps2_mouse_packet_rx_if.master  bus
);
  localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYC);
`ifdef PS2_WHEEL_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic           clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic           dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           strobe;
  state_e         state_q, state_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           byte_valid_q, byte_valid_d;
  logic [7:0]     byte_data_q, byte_data_d;
  logic           frame_err_q, frame_err_d;
  logic [1:0]     idx_q, idx_d;
  logic [7:0]     b0_q, b0_d, bx_q, bx_d;
  logic           pkt_valid_q, pkt_valid_d;
  logic [2:0]     buttons_q, buttons_d;
  logic [8:0]     dx_q, dx_d, dy_q, dy_d;
  logic           x_ovf_q, x_ovf_d, y_ovf_q, y_ovf_d;
  logic [7:0]     ybyte;
`ifdef PS2_WHEEL_EN
  logic [7:0]     by_q, by_d;
  logic [3:0]     dz_q, dz_d;
`endif

  always_comb begin
    clk_s1_d = PS2CLK;
    clk_s2_d = clk_s1_q;
    dat_s1_d = PS2DATA;
    dat_s2_d = dat_s1_q;

    // A level change is accepted on the FILTER_LEN-th consecutive differing
    // sample; the strobe fires in that same cycle for a 1->0 change only.
    filt_d = filt_q;
    fcnt_d = '0;
    strobe = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        strobe = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    state_d      = state_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tcnt_d       = tcnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    frame_err_d  = 1'b0;
    if (!bus.rx_en) begin
      state_d = IDLE;
      tcnt_d  = '0;
    end else begin
      if (state_q == IDLE || strobe) tcnt_d = '0;
      else                           tcnt_d = tcnt_q + 1'b1;
      if (strobe) begin
        case (state_q)
          IDLE: if (!dat_s2_q) begin
            state_d = DATA;
            bit_d   = '0;
          end
          DATA: begin
            shift_d = {dat_s2_q, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = PARITY;
          end
          PARITY: begin
            par_d   = dat_s2_q;
            state_d = STOP;
          end
          default: begin
            state_d = IDLE;
            if ((^{shift_q, par_q}) && dat_s2_q) begin
              byte_valid_d = 1'b1;
              byte_data_d  = shift_q;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        endcase
      end else if (state_q != IDLE && tcnt_d == TCW'(TIMEOUT_CYC - 1)) begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end
    end

    idx_d       = idx_q;
    b0_d        = b0_q;
    bx_d        = bx_q;
    pkt_valid_d = 1'b0;
    buttons_d   = buttons_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    x_ovf_d     = x_ovf_q;
    y_ovf_d     = y_ovf_q;
`ifdef PS2_WHEEL_EN
    by_d  = by_q;
    dz_d  = dz_q;
    ybyte = by_q;
`else
    ybyte = byte_data_q;
`endif
    if (!bus.rx_en || frame_err_q) begin
      idx_d = '0;
    end else if (byte_valid_q) begin
      if (idx_q == 2'd0) begin
        // Bit 3 of byte 0 is always set; anything else is a resync drop.
        if (byte_data_q[3]) begin
          b0_d  = byte_data_q;
          idx_d = 2'd1;
        end
      end else if (idx_q == LAST_IDX) begin
        buttons_d   = b0_q[2:0];
        dx_d        = {b0_q[4], bx_q};
        dy_d        = {b0_q[5], ybyte};
        x_ovf_d     = b0_q[6];
        y_ovf_d     = b0_q[7];
`ifdef PS2_WHEEL_EN
        dz_d        = byte_data_q[3:0];
`endif
        pkt_valid_d = 1'b1;
        idx_d       = '0;
      end else if (idx_q == 2'd1) begin
        bx_d  = byte_data_q;
        idx_d = 2'd2;
      end else begin
`ifdef PS2_WHEEL_EN
        by_d  = byte_data_q;
        idx_d = 2'd3;
`else
        idx_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      state_q      <= IDLE;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tcnt_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
      idx_q        <= '0;
      b0_q         <= '0;
      bx_q         <= '0;
      pkt_valid_q  <= 1'b0;
      buttons_q    <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      x_ovf_q      <= 1'b0;
      y_ovf_q      <= 1'b0;
`ifdef PS2_WHEEL_EN
      by_q         <= '0;
      dz_q         <= '0;
`endif
    end else begin
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tcnt_q       <= tcnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
      idx_q        <= idx_d;
      b0_q         <= b0_d;
      bx_q         <= bx_d;
      pkt_valid_q  <= pkt_valid_d;
      buttons_q    <= buttons_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      x_ovf_q      <= x_ovf_d;
      y_ovf_q      <= y_ovf_d;
`ifdef PS2_WHEEL_EN
      by_q         <= by_d;
      dz_q         <= dz_d;
`endif
    end
  end

  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.pkt_valid  = pkt_valid_q;
  assign bus.buttons    = buttons_q;
  assign bus.dx         = dx_q;
  assign bus.dy         = dy_q;
  assign bus.x_ovf      = x_ovf_q;
  assign bus.y_ovf      = y_ovf_q;
`ifdef PS2_WHEEL_EN
  assign bus.dz         = dz_q;
`endif
endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Bench for ps2_mouse_packet_rx (default 3-byte build): directed scenarios
// plus randomized frames against a byte/packet-level reference model.
module tb_ps2_mouse_packet_rx;
  localparam int FLEN = 8;
  localparam int TOUT = 300;
  localparam int HALF = 20;
  localparam int GAP  = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2clk = 1'b1;
  logic ps2data = 1'b1;
  int   cyc = 0;

  ps2_mouse_packet_rx_if bus();

  ps2_mouse_packet_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT)) dut (
    .CLK(clk), .RST(rst_n), .PS2CLK(ps2clk), .PS2DATA(ps2data), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [7:0]  exp_b[$];
  logic [31:0] exp_p[$];
  int          exp_err = 0;
  logic [7:0]  pk[$];

  // observed events
  logic [7:0]  obs_b[$];
  logic [31:0] obs_p[$];
  int          obs_err = 0;
  int          last_bv = 0, last_fe = 0, last_fall = 0;

  function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    return {9'd0, b0[6], b0[7], b0[2:0], b0[4], b1, b0[5], b2};
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err++;
      pk.delete();
      return;
    end
    exp_b.push_back(b);
    if (pk.size() == 0 && !b[3]) return;
    pk.push_back(b);
    if (pk.size() == 3) begin
      exp_p.push_back(pack(pk[0], pk[1], pk[2]));
      pk.delete();
    end
  endtask

  always @(negedge clk) begin
    if (bus.byte_valid) begin obs_b.push_back(bus.byte_data); last_bv = cyc; end
    if (bus.frame_err)  begin obs_err++; last_fe = cyc; end
    if (bus.pkt_valid)
      obs_p.push_back({9'd0, bus.x_ovf, bus.y_ovf, bus.buttons, bus.dx, bus.dy});
    if (bus.frame_err && (bus.byte_valid || bus.pkt_valid))
      check_val("excl", {bus.byte_valid, bus.pkt_valid}, 0);
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2clk = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      ps2clk = 1'b1;
    end
    ps2data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    repeat (GAP) @(negedge clk);
    model_byte(b, !(bad_par || bad_stop));
  endtask

  task automatic check_sb(input string tag);
    check_val({tag, "_nbytes"}, obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++)
      check_val({tag, "_byte"}, obs_b[i], exp_b[i]);
    check_val({tag, "_npkts"}, obs_p.size(), exp_p.size());
    for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++)
      check_val({tag, "_pkt"}, obs_p[i], exp_p[i]);
    check_val({tag, "_errs"}, obs_err, exp_err);
    exp_b.delete(); obs_b.delete(); exp_p.delete(); obs_p.delete();
    exp_err = 0; obs_err = 0;
  endtask

  task automatic check_outs_zero(input string tag);
    check_val({tag, "_pulses"}, {bus.byte_valid, bus.frame_err, bus.pkt_valid}, 0);
    check_val({tag, "_bdata"}, bus.byte_data, 0);
    check_val({tag, "_pkt"}, {bus.x_ovf, bus.y_ovf, bus.buttons, bus.dx, bus.dy}, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    logic [7:0] b;
    int r;
    bus.rx_en = 1'b1;
    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_outs_zero("post_reset");

    // 1: basic packet
    send_frame(8'h29, 0, 0);
    send_frame(8'h05, 0, 0);
    send_frame(8'hFB, 0, 0);
    lat = last_bv - last_fall;
    check_val("lat_range", (lat >= FLEN && lat <= FLEN + 4), 1);
    check_val("t1_buttons", bus.buttons, 3'b001);
    check_val("t1_dx", bus.dx, 9'h005);
    check_val("t1_dy", bus.dy, 9'h1FB);
    check_sb("t1");

    // 2: parity error discards partial packet
    send_frame(8'h08, 0, 0);
    send_frame(8'h10, 1, 0);
    send_frame(8'h08, 0, 0);
    send_frame(8'h01, 0, 0);
    send_frame(8'h02, 0, 0);
    check_val("t2_dx", bus.dx, 9'h001);
    check_val("t2_dy", bus.dy, 9'h002);
    check_sb("t2");

    // 3: resync on byte 0 without bit 3
    send_frame(8'h00, 0, 0);
    send_frame(8'h08, 0, 0);
    send_frame(8'h7F, 0, 0);
    send_frame(8'h80, 0, 0);
    check_val("t3_dx", bus.dx, 9'h07F);
    check_val("t3_dy", bus.dy, 9'h080);
    check_sb("t3");

    // 4: timeout after 5 data bits
    send_frame(8'h08, 0, 0);
    send_bits(11'b000_0001_0110, 6);
    seen = 0;
    for (int i = 0; i < TOUT + 100 && !seen; i++) begin
      @(negedge clk);
      if (obs_err != 0) seen = 1;
    end
    check_val("to_seen", seen, 1);
    check_val("to_cycles", last_fe - last_fall, lat - 1 + TOUT);
    model_byte(8'h00, 0);
    repeat (GAP) @(negedge clk);
    send_frame(8'h18, 0, 0);
    send_frame(8'h33, 0, 0);
    send_frame(8'h44, 0, 0);
    check_sb("t4");

    // 5: short low glitch on PS2CLK with data low
    ps2data = 1'b0;
    @(negedge clk) ps2clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2clk = 1'b1;
    repeat (GAP) @(negedge clk);
    ps2data = 1'b1;
    repeat (GAP) @(negedge clk);
    check_sb("t5_glitch");
    send_frame(8'h28, 0, 0);
    send_frame(8'h11, 0, 0);
    send_frame(8'h22, 0, 0);
    check_sb("t5");

    // 6: rx_en abort mid-frame, then reset mid-packet
    send_frame(8'h09, 0, 0);
    send_bits(11'b101_0101_0100, 4);
    repeat (HALF) @(negedge clk);
    bus.rx_en = 1'b0;
    pk.delete();
    repeat (10) @(negedge clk);
    bus.rx_en = 1'b1;
    repeat (GAP) @(negedge clk);
    send_frame(8'h0A, 0, 0);
    send_frame(8'h55, 0, 0);
    send_frame(8'hAA, 0, 0);
    check_sb("t6");
    send_frame(8'h08, 0, 0);
    send_frame(8'h01, 0, 0);
    check_sb("t6_pre_rst");
    #3 rst_n = 1'b0;
    #1 check_outs_zero("t6_rst");
    pk.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h3C, 0, 0);
    send_frame(8'h12, 0, 0);
    send_frame(8'hF0, 0, 0);
    check_sb("t6_post");

    // randomized frames, occasional parity/stop errors
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom);
      r = $urandom_range(0, 15);
      send_frame(b, r < 2, r == 2);
    end
    check_sb("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
